// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: clear-sequencer states and depth helper.
package rf_pkg;

  typedef enum logic [1:0] {
    RF_IDLE  = 2'd0,
    RF_CLEAR = 2'd1,
    RF_DONE  = 2'd2
  } rf_state_e;

  function automatic int unsigned rf_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Host (AXI debug/control) side of the register file: write, read-back and clear control.
interface reg_file_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              axi_reg_we_i;
  logic [ADDR_W-1:0] axi_addr_d_i;
  logic [DATA_W-1:0] axi_data_d_i;
  logic              axi_rd_req_i;
  logic [ADDR_W-1:0] axi_rd_addr_i;
  logic [DATA_W-1:0] axi_rd_data_o;
  logic              axi_rd_vld_o;
  logic              clr_req_i;
  logic              clr_busy_o;
  logic              clr_done_o;

  modport master (
    output axi_reg_we_i, axi_addr_d_i, axi_data_d_i, axi_rd_req_i, axi_rd_addr_i, clr_req_i,
    input  axi_rd_data_o, axi_rd_vld_o, clr_busy_o, clr_done_o
  );

  modport slave (
    input  axi_reg_we_i, axi_addr_d_i, axi_data_d_i, axi_rd_req_i, axi_rd_addr_i, clr_req_i,
    output axi_rd_data_o, axi_rd_vld_o, clr_busy_o, clr_done_o
  );
endinterface

// File: rtl/reg_file_mp_clear.sv
// Clear sequencer: walks every entry once, one per cycle, then pulses done for a single cycle.
module rf_clear_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req_i,
  output logic              clr_en_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              busy_o,
  output logic              done_o
);

  rf_state_e         state_q;
  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        RF_IDLE: begin
          if (clr_req_i) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
          end
        end
        RF_CLEAR: begin
          // Last entry: park the counter at zero instead of letting it wrap.
          if (cnt_q == '1) begin
            state_q <= RF_DONE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        RF_DONE:  state_q <= RF_IDLE;
        default:  state_q <= RF_IDLE;
      endcase
    end
  end

  assign clr_en_o   = (state_q == RF_CLEAR);
  assign busy_o     = (state_q == RF_CLEAR);
  assign done_o     = (state_q == RF_DONE);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port GPR array: N bypassed combinational reads, core + host writes (host wins),
// registered host read-back and a sequenced clear driven from the host side.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_RD  = 2,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reg_we_i,
  input  logic [ADDR_W-1:0]        addr_d_i,
  input  logic [DATA_W-1:0]        data_d_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic                     wr_clash_o,
  reg_file_mp_if.slave             host
);

  localparam int unsigned DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] axi_rd_data_q, axi_rd_data_d;
  logic              axi_rd_vld_q, axi_rd_vld_d;
  logic              wr_clash_q, wr_clash_d;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              core_we, host_we;

  rf_clear_ctrl #(.ADDR_W(ADDR_W)) u_clr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req_i  (host.clr_req_i),
    .clr_en_o   (clr_en),
    .clr_addr_o (clr_addr),
    .busy_o     (host.clr_busy_o),
    .done_o     (host.clr_done_o)
  );

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !(ZERO_R0 && (a == '0));
  endfunction

  // Effective enables already exclude clear cycles, so bypass is disabled while clearing.
  function automatic logic [DATA_W-1:0] rd_mux(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              hwe,
    input logic [ADDR_W-1:0] ha,
    input logic [DATA_W-1:0] hd,
    input logic              cwe,
    input logic [ADDR_W-1:0] ca,
    input logic [DATA_W-1:0] cd
  );
    if (ZERO_R0 && (a == '0)) return '0;
    if (hwe && (a == ha))     return hd;
    if (cwe && (a == ca))     return cd;
    return stored;
  endfunction

  assign core_we = reg_we_i && !clr_en && writable(addr_d_i);
  assign host_we = host.axi_reg_we_i && !clr_en && writable(host.axi_addr_d_i);

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign rd_data_o[k*DATA_W +: DATA_W] =
      rd_mux(a, mem_q[a], host_we, host.axi_addr_d_i, host.axi_data_d_i,
             core_we, addr_d_i, data_d_i);
  end

  always_comb begin
    mem_d = mem_q;
    if (clr_en) begin
      mem_d[clr_addr] = '0;
    end else begin
      if (core_we) mem_d[addr_d_i] = data_d_i;
      if (host_we) mem_d[host.axi_addr_d_i] = host.axi_data_d_i;
    end
  end

  always_comb begin
    axi_rd_vld_d  = host.axi_rd_req_i;
    axi_rd_data_d = axi_rd_data_q;
    if (host.axi_rd_req_i)
      axi_rd_data_d = rd_mux(host.axi_rd_addr_i, mem_q[host.axi_rd_addr_i],
                             host_we, host.axi_addr_d_i, host.axi_data_d_i,
                             core_we, addr_d_i, data_d_i);
    wr_clash_d = core_we && host_we && (addr_d_i == host.axi_addr_d_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q         <= '{default: '0};
      axi_rd_data_q <= '0;
      axi_rd_vld_q  <= 1'b0;
      wr_clash_q    <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      axi_rd_data_q <= axi_rd_data_d;
      axi_rd_vld_q  <= axi_rd_vld_d;
      wr_clash_q    <= wr_clash_d;
    end
  end

  assign host.axi_rd_data_o = axi_rd_data_q;
  assign host.axi_rd_vld_o  = axi_rd_vld_q;
  assign wr_clash_o         = wr_clash_q;

endmodule
